// File: rtl/aes_dec_ctrl.sv
// aes_dec_ctrl: control FSM for the AES-128 inverse cipher datapath.
// Round keys are walked in reverse order: B10 in INIT, B9..B1 in ROUND and B0 in FINAL.
// Every output is either decoded from the state or taken straight from a register,
// so no input has a combinational path to an output.
// Optional build macro: AES_DEC_ABORT_EN adds the abort input. When it is set,
// abort cancels an operation in flight, and outValid is never raised for that block.
module aes_dec_ctrl #(
    parameter int unsigned NR  = 10,
    parameter int unsigned RKW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           keyReady,
    input  logic           outReady,
`ifdef AES_DEC_ABORT_EN
    input  logic           abort,
`endif
    output logic           busy,
    output logic           startAck,
    output logic           loadIn,
    output logic           stateEn,
    output logic           invMixEn,
    output logic           lastRound,
    output logic [RKW-1:0] rkSel,
    output logic           outValid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [RKW-1:0] RK_LAST = RKW'(NR);
    localparam logic [RKW-1:0] RK_ONE  = RKW'(1);

    state_t         state_q, state_d;
    logic [RKW-1:0] rkSel_q, rkSel_d;
    logic           startAck_q, startAck_d;
    logic           accept;

    // State, round-key index and acknowledge registers; reset returns to IDLE with index NR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rkSel_q    <= RK_LAST;
            startAck_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rkSel_q    <= rkSel_d;
            startAck_q <= startAck_d;
        end
    end

    // Next state, next round-key index, and the outputs decoded from the current state.
    always_comb begin
        state_d    = state_q;
        rkSel_d    = rkSel_q;
        startAck_d = 1'b0;
        accept     = start & keyReady;

        busy      = 1'b0;
        loadIn    = 1'b0;
        stateEn   = 1'b0;
        invMixEn  = 1'b0;
        lastRound = 1'b0;
        outValid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                rkSel_d = RK_LAST;
                if (accept) begin
                    state_d    = S_INIT;
                    startAck_d = 1'b1;
                end
            end
            S_INIT: begin
                busy    = 1'b1;
                loadIn  = 1'b1;
                stateEn = 1'b1;
                state_d = S_ROUND;
                rkSel_d = RK_LAST - RK_ONE;
            end
            S_ROUND: begin
                busy     = 1'b1;
                stateEn  = 1'b1;
                invMixEn = 1'b1;
                if (rkSel_q == RK_ONE) begin
                    state_d = S_FINAL;
                    rkSel_d = '0;
                end else begin
                    rkSel_d = rkSel_q - RK_ONE;
                end
            end
            S_FINAL: begin
                busy      = 1'b1;
                stateEn   = 1'b1;
                lastRound = 1'b1;
                state_d   = S_DONE;
                rkSel_d   = '0;
            end
            S_DONE: begin
                outValid = 1'b1;
                if (outReady) begin
                    rkSel_d = RK_LAST;
                    if (accept) begin
                        state_d    = S_INIT;
                        startAck_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                rkSel_d = RK_LAST;
            end
        endcase

`ifdef AES_DEC_ABORT_EN
        // Abort only affects INIT, ROUND and FINAL. In IDLE and DONE it has no effect.
        if (abort && (state_q == S_INIT || state_q == S_ROUND || state_q == S_FINAL)) begin
            state_d = S_IDLE;
            rkSel_d = RK_LAST;
        end
`endif
    end

    assign startAck = startAck_q;
    assign rkSel    = rkSel_q;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Testbench for aes_dec_ctrl.
// The stimulus process queues the expected per-cycle control word for every cycle
// in which the DUT should show activity (busy, outValid or startAck).
// A monitor on the falling edge pops and compares an entry whenever the DUT shows
// any activity. Abort cases are compiled in when AES_DEC_ABORT_EN is defined.
module tb_aes_dec_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, keyReady, outReady;
`ifdef AES_DEC_ABORT_EN
    logic       abort;
`endif
    logic       busy, startAck, loadIn, stateEn, invMixEn, lastRound, outValid;
    logic [3:0] rkSel;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       ack;
        logic       bsy;
        logic       load;
        logic       sten;
        logic       imx;
        logic       last;
        logic       ov;
        logic       rkchk;
        logic [3:0] rk;
    } exp_t;

    exp_t q[$];
    exp_t e_m, a_m;

    aes_dec_ctrl #(.NR(10), .RKW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .keyReady  (keyReady),
        .outReady  (outReady),
`ifdef AES_DEC_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .startAck  (startAck),
        .loadIn    (loadIn),
        .stateEn   (stateEn),
        .invMixEn  (invMixEn),
        .lastRound (lastRound),
        .rkSel     (rkSel),
        .outValid  (outValid)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic ack, input logic bsy, input logic load,
                                input logic sten, input logic imx, input logic last,
                                input logic ov, input logic rkc, input logic [3:0] rk);
        mk = {ack, bsy, load, sten, imx, last, ov, rkc, rk};
    endfunction

    // Expected words for INIT (B10), ROUND (B9..B1) and FINAL (B0).
    task automatic push_run();
        q.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1, 4'd10));
        for (int r = 9; r >= 1; r--) q.push_back(mk(0, 1, 0, 1, 1, 0, 0, 1, 4'(r)));
        q.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, 4'd0));
    endtask

    // Expected words for a partial run: INIT, followed by ROUND cycles down to index lo.
    task automatic push_partial(input int lo);
        q.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1, 4'd10));
        for (int r = 9; r >= lo; r--) q.push_back(mk(0, 1, 0, 1, 1, 0, 0, 1, 4'(r)));
    endtask

    // Expected DONE cycles: outValid is high and stateEn is low. rkSel is not checked here.
    task automatic push_done(input int n);
        for (int i = 0; i < n; i++) q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 4'd0));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Monitor: whenever the DUT shows activity, compare it with the next queued word.
    always @(negedge clk) begin
        if (busy || outValid || startAck) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output actual busy=%0b ov=%0b ack=%0b rk=%0d required=idle",
                         busy, outValid, startAck, rkSel);
            end else begin
                e_m = q.pop_front();
                a_m = {startAck, busy, loadIn, stateEn, invMixEn, lastRound, outValid,
                       e_m.rkchk, (e_m.rkchk ? rkSel : 4'd0)};
                if (a_m !== e_m) begin
                    failures++;
                    $display("FAIL ctrl_word actual=%h required=%h (ack,busy,load,sten,imx,last,ov,rkchk,rk)",
                             a_m, e_m);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; keyReady = 1'b0; outReady = 1'b0;
`ifdef AES_DEC_ABORT_EN
        abort = 1'b0;
`endif
        // Reset held for two edges.
        cyc(2);
        chk("reset_busy", int'(busy), 0);
        chk("reset_outValid", int'(outValid), 0);
        chk("reset_startAck", int'(startAck), 0);
        chk("reset_rkSel", int'(rkSel), 10);
        reset = 1'b0;
        cyc(3);
        chk("idle_busy", int'(busy), 0);
        chk("idle_rkSel", int'(rkSel), 10);

        // Single block: outValid appears 12 cycles after the start cycle and lasts one cycle.
        keyReady = 1'b1; outReady = 1'b1; start = 1'b1;
        push_run(); push_done(1);
        cyc(1); start = 1'b0;
        cyc(14);
        chk("single_drain", q.size(), 0);

        // A start with keyReady low is ignored and is not queued.
        keyReady = 1'b0; start = 1'b1;
        cyc(1); start = 1'b0;
        chk("nokey_startAck", int'(startAck), 0);
        chk("nokey_busy", int'(busy), 0);
        cyc(3);
        chk("nokey_still_idle", int'(busy), 0);

        // A normal run, then DONE held for 5 cycles, then back-to-back into the next block.
        keyReady = 1'b1; outReady = 1'b0; start = 1'b1;
        push_run(); push_done(5);
        cyc(1); start = 1'b0;   // INIT
        cyc(11);                // first DONE cycle
        chk("hold_stateEn", int'(stateEn), 0);
        cyc(4);                 // fifth DONE cycle: accept and restart
        outReady = 1'b1; start = 1'b1;
        push_run(); push_done(1);
        cyc(1); start = 1'b0;   // INIT directly, with no IDLE cycle
        chk("b2b_loadIn", int'(loadIn), 1);
        cyc(13);
        chk("b2b_drain", q.size(), 0);

        // Reset while rkSel is 5: the DUT goes to IDLE and outValid never rises.
        start = 1'b1;
        push_partial(5);
        cyc(1); start = 1'b0;
        cyc(5);
        chk("pre_reset_rkSel", int'(rkSel), 5);
        reset = 1'b1;
        cyc(1);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_rkSel", int'(rkSel), 10);
        reset = 1'b0;
        cyc(15);
        chk("midreset_drain", q.size(), 0);

`ifdef AES_DEC_ABORT_EN
        // Abort while rkSel is 3, then a normal run afterwards.
        start = 1'b1;
        push_partial(3);
        cyc(1); start = 1'b0;
        cyc(7);
        abort = 1'b1;
        cyc(1); abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_rkSel", int'(rkSel), 10);
        cyc(3);
        start = 1'b1;
        push_run(); push_done(1);
        cyc(1); start = 1'b0;
        cyc(14);
        chk("abort_drain", q.size(), 0);
`endif

        cyc(2);
        chk("final_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
